pc_fetch: RTL and testbench

Instruction-fetch stage of the single-issue CPU datapath. Holds the program counter and issues one instruction-memory read at a time. Buffers the returned word and hands it to decode with a valid/ready handshake. Computes the sequential next PC (PC+4) with the team's 32-bit adder and accepts branch/jump redirects from execute.

---
 rtl/fetch_pkg.sv | 25 ++
 rtl/pc_fetch_add_32.sv | 11 +
 rtl/pc_fetch.sv | 141 ++++++++++++++
 tb/tb_pc_fetch.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// The HALT state only exists when PC_FETCH_ALIGN_CHECK_EN is defined.
package fetch_pkg;

    localparam int          INST_W  = 32;
    localparam logic [31:0] PC_STEP = 32'd4;

`ifdef PC_FETCH_ALIGN_CHECK_EN
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_HOLD  = 3'd2,
        ST_FLUSH = 3'd3,
        ST_HALT  = 3'd4
    } fetch_state_e;
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_HOLD  = 3'd2,
        ST_FLUSH = 3'd3
    } fetch_state_e;
`endif

endpackage

// File: rtl/pc_fetch_add_32.sv
// 32-bit adder used for the sequential next-PC; carry out is discarded so
// the sum wraps modulo 2^32.
module add_32 (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] sum_o
);

    assign sum_o = a_i + b_i;

endmodule

// File: rtl/pc_fetch.sv
// Instruction-fetch stage: PC register, single-outstanding imem reads, one-entry
// instruction buffer to decode. Misaligned-redirect trap under PC_FETCH_ALIGN_CHECK_EN.
module pc_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    output logic              imem_req_o,
    output logic [31:0]       imem_addr_o,
    input  logic              imem_rvalid_i,
    input  logic [INST_W-1:0] imem_rdata_i,
    output logic              inst_valid_o,
    input  logic              inst_ready_i,
    output logic [INST_W-1:0] inst_o,
    output logic [31:0]       inst_pc_o,
    input  logic              redirect_valid_i,
    input  logic [31:0]       redirect_pc_i,
    output logic              fetch_err_o
);

    fetch_state_e      state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic [31:0]       inst_pc_q, inst_pc_d;
    logic [31:0]       pc_plus4;
    logic [31:0]       redir_pc;
    logic              req_c;

    add_32 u_add_32 (
        .a_i   (pc_q),
        .b_i   (PC_STEP),
        .sum_o (pc_plus4)
    );

    assign redir_pc = redirect_pc_i & ~32'd3;

`ifdef PC_FETCH_ALIGN_CHECK_EN
    logic fetch_err_q, fetch_err_d;
    logic misaligned;

    assign misaligned = redirect_valid_i && (redirect_pc_i[1:0] != 2'b00);
`endif

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        req_c     = 1'b0;
`ifdef PC_FETCH_ALIGN_CHECK_EN
        fetch_err_d = fetch_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (redirect_valid_i) begin
                    pc_d = redir_pc;
                end else begin
                    req_c   = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect_valid_i) begin
                    pc_d    = redir_pc;
                    state_d = imem_rvalid_i ? ST_IDLE : ST_FLUSH;
                end else if (imem_rvalid_i) begin
                    inst_d    = imem_rdata_i;
                    inst_pc_d = pc_q;
                    pc_d      = pc_plus4;
                    state_d   = ST_HOLD;
                end
            end
            ST_FLUSH: begin
                // A redirect coinciding with the stale response still retires
                // it; staying in FLUSH then would wait for a reply never coming.
                if (redirect_valid_i) begin
                    pc_d = redir_pc;
                end
                if (imem_rvalid_i) begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (redirect_valid_i) begin
                    pc_d    = redir_pc;
                    state_d = ST_IDLE;
                end else if (inst_ready_i) begin
                    req_c   = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            default: begin
            end
        endcase
`ifdef PC_FETCH_ALIGN_CHECK_EN
        if (misaligned && state_q != ST_HALT) begin
            state_d     = ST_HALT;
            pc_d        = pc_q;
            req_c       = 1'b0;
            fetch_err_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            pc_q      <= RESET_PC;
            inst_q    <= '0;
            inst_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
        end
    end

`ifdef PC_FETCH_ALIGN_CHECK_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_err_q <= 1'b0;
        end else begin
            fetch_err_q <= fetch_err_d;
        end
    end

    assign fetch_err_o = fetch_err_q;
`else
    assign fetch_err_o = 1'b0;
`endif

    assign imem_req_o   = req_c & ~rst_i;
    assign imem_addr_o  = pc_q;
    assign inst_valid_o = (state_q == ST_HOLD);
    assign inst_o       = inst_q;
    assign inst_pc_o    = inst_pc_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Bench for pc_fetch: directed scenarios plus a randomized run, checked against
// a stream-level model (expected next PC, memory contents, one outstanding read).
module tb_pc_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_err;

    always #5 clk = ~clk;

    pc_fetch #(.RESET_PC(RST_PC)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .imem_req_o       (imem_req),
        .imem_addr_o      (imem_addr),
        .imem_rvalid_i    (imem_rvalid),
        .imem_rdata_i     (imem_rdata),
        .inst_valid_o     (inst_valid),
        .inst_ready_i     (inst_ready),
        .inst_o           (inst),
        .inst_pc_o        (inst_pc),
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redirect_pc),
        .fetch_err_o      (fetch_err)
    );

    int n_pass = 0;
    int n_total = 0;

    // sampled outputs of the most recent cycle
    logic        s_req, s_valid, s_err;
    logic [31:0] s_addr, s_inst, s_inst_pc;

    // reference model state
    logic [31:0] exp_pc;
    logic        prev_redir, prev_stall;
    logic [31:0] held_inst, held_pc;
    bit          model_en = 1'b1;
    int          xfers = 0;
    int          pend = 0;
    int          mem_lat = 1;
    logic [31:0] pend_addr;

    function automatic logic [31:0] memw(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, expv);
    endtask

    // One clock cycle: sample at negedge, run the model, then after the edge
    // drive the memory response and end any redirect pulse.
    task automatic cycle();
        @(negedge clk);
        s_req = imem_req; s_addr = imem_addr; s_valid = inst_valid;
        s_inst = inst; s_inst_pc = inst_pc; s_err = fetch_err;
        if (rst) begin
            chk("req_in_reset", 32'(s_req), 32'd0);
            exp_pc = RST_PC; prev_redir = 1'b0; prev_stall = 1'b0;
        end else if (model_en) begin
            if (redirect_valid) chk("req_on_redirect", 32'(s_req), 32'd0);
            if (prev_redir) chk("valid_after_redirect", 32'(s_valid), 32'd0);
            if (prev_stall) begin
                chk("stall_valid", 32'(s_valid), 32'd1);
                chk("stall_inst", s_inst, held_inst);
                chk("stall_inst_pc", s_inst_pc, held_pc);
            end
            if (s_valid && inst_ready && !redirect_valid) begin
                chk("xfer_pc", s_inst_pc, exp_pc);
                chk("xfer_inst", s_inst, memw(exp_pc));
                exp_pc = exp_pc + 32'd4;
                xfers++;
            end
            if (s_req) begin
                chk("req_addr", s_addr, exp_pc);
                chk("one_outstanding", 32'(pend), 32'd0);
            end
            if (redirect_valid) exp_pc = {redirect_pc[31:2], 2'b00};
            prev_redir = redirect_valid;
            prev_stall = s_valid && !inst_ready && !redirect_valid;
            held_inst = s_inst; held_pc = s_inst_pc;
        end
        if (s_req) begin
            pend = mem_lat;
            pend_addr = s_addr;
        end
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata = memw(pend_addr);
            end
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        redirect_valid = 1'b0;
        for (int i = 0; i < n; i++) cycle();
        chk("rst_valid", 32'(s_valid), 32'd0);
        chk("rst_inst", s_inst, 32'd0);
        chk("rst_inst_pc", s_inst_pc, 32'd0);
        chk("rst_err", 32'(s_err), 32'd0);
        chk("rst_addr", s_addr, RST_PC);
        rst = 1'b0;
    endtask

    task automatic wait_req(input int max_cyc, output bit found);
        found = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            cycle();
            if (s_req) begin
                found = 1'b1;
                return;
            end
        end
    endtask

    task automatic wait_valid(input int max_cyc, output bit found);
        found = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            cycle();
            if (s_valid) begin
                found = 1'b1;
                return;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        int x0;
        rst = 1'b1; inst_ready = 1'b1; redirect_valid = 1'b0;
        redirect_pc = '0; imem_rvalid = 1'b0; imem_rdata = '0;

        // reset, then back-to-back fetch with 1-cycle memory
        do_reset(3);
        mem_lat = 1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("seq_req", 32'(s_req), 32'((i % 2) == 0));
            if ((i % 2) == 0) chk("seq_addr", s_addr, RST_PC + 32'(4 * (i / 2)));
            if (i == 2 || i == 4) begin
                chk("seq_valid", 32'(s_valid), 32'd1);
                chk("seq_inst_pc", s_inst_pc, RST_PC + 32'(4 * (i / 2 - 1)));
            end
        end

        // backpressure: hold for 5 cycles, then exactly one transfer
        inst_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("bp_valid", 32'(s_valid), 32'd1);
            chk("bp_req", 32'(s_req), 32'd0);
            chk("bp_inst_pc", s_inst_pc, 32'h0000_3008);
            chk("bp_inst", s_inst, memw(32'h0000_3008));
        end
        inst_ready = 1'b1;
        cycle();
        chk("bp_release_req", 32'(s_req), 32'd1);
        chk("bp_release_addr", s_addr, 32'h0000_300C);
        cycle();
        chk("bp_single_xfer", 32'(s_valid), 32'd0);

        // redirect during WAIT with 3-cycle memory -> FLUSH
        mem_lat = 3;
        wait_req(20, ok);
        chk("flush_setup_timeout", 32'(ok), 32'd1);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
        cycle();
        cycle(); chk("flush_req_a", 32'(s_req), 32'd0);
        cycle(); chk("flush_req_b", 32'(s_req), 32'd0);
        chk("flush_stale_arrives", 32'(imem_rvalid), 32'd0);
        cycle();
        chk("flush_req_c", 32'(s_req), 32'd1);
        chk("flush_addr", s_addr, 32'h0000_0100);
        chk("flush_no_valid", 32'(s_valid), 32'd0);

        // redirect together with ready in HOLD
        mem_lat = 1; inst_ready = 1'b0;
        wait_valid(20, ok);
        chk("hold_setup_timeout", 32'(ok), 32'd1);
        inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
        cycle();
        cycle();
        chk("hold_redir_valid", 32'(s_valid), 32'd0);
        chk("hold_redir_req", 32'(s_req), 32'd1);
        chk("hold_redir_addr", s_addr, 32'h0000_0200);

        // PC wrap at the top of the address space
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        cycle();
        wait_req(20, ok);
        chk("wrap_req1_timeout", 32'(ok), 32'd1);
        chk("wrap_addr1", s_addr, 32'hFFFF_FFFC);
        wait_req(20, ok);
        chk("wrap_req2_timeout", 32'(ok), 32'd1);
        chk("wrap_addr2", s_addr, 32'h0000_0000);

        // randomized traffic with a reset dropped in the middle
        x0 = xfers;
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) begin
                do_reset(4);
                cycle();
                chk("midrst_req", 32'(s_req), 32'd1);
                chk("midrst_addr", s_addr, RST_PC);
            end
            inst_ready = ($urandom_range(0, 3) != 0);
            mem_lat = $urandom_range(1, 3);
            if ($urandom_range(0, 11) == 0) begin
                redirect_valid = 1'b1;
`ifdef PC_FETCH_ALIGN_CHECK_EN
                redirect_pc = $urandom & ~32'd3;
`else
                redirect_pc = $urandom;
`endif
            end
            cycle();
        end
        chk("rand_liveness", 32'(xfers > x0 + 100), 32'd1);
        inst_ready = 1'b1; mem_lat = 1;

`ifdef PC_FETCH_ALIGN_CHECK_EN
        model_en = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0102;
        cycle();
        for (int i = 0; i < 6; i++) begin
            if (i == 2) begin
                redirect_valid = 1'b1; redirect_pc = 32'h0000_0400;
            end
            cycle();
            chk("halt_err", 32'(s_err), 32'd1);
            chk("halt_req", 32'(s_req), 32'd0);
            chk("halt_valid", 32'(s_valid), 32'd0);
        end
        do_reset(3);
        model_en = 1'b1;
        cycle();
        chk("halt_restart_req", 32'(s_req), 32'd1);
        chk("halt_restart_addr", s_addr, RST_PC);
`else
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0102;
        cycle();
        wait_req(20, ok);
        chk("mask_timeout", 32'(ok), 32'd1);
        chk("mask_addr", s_addr, 32'h0000_0100);
        chk("mask_err", 32'(s_err), 32'd0);
`endif
        for (int i = 0; i < 4; i++) cycle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
